inv_sub_word_iter: RTL

Iterative InvSubBytes engine for the AES-128 decryption datapath: accepts a 128-bit state and replaces every byte with its inverse S-box value. The encryption path substitutes a 32-bit word combinationally; this block does the reverse operation sequentially through LANES shared inverse S-box instances, trading latency for area. It sits between InvShiftRows and AddRoundKey in the decrypt round loop, with valid/ready handshakes on both sides.

---
 rtl/inv_sub_word_iter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/inv_sub_word_iter.sv
// Iterative AES InvSubBytes over a 128-bit state, LANES bytes per clock.
// Defining INV_SUB_FWD_CHECK_EN adds a forward S-box round-trip check driving chk_err.
module inv_sub_word_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         chk_err
);
  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("inv_sub_word_iter: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // FIPS-197 inverse S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_TBL[2047 - 8 * int'(x) -: 8];
  endfunction

`ifdef INV_SUB_FWD_CHECK_EN
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    return FWD_TBL[2047 - 8 * int'(x) -: 8];
  endfunction

  logic [LANES-1:0] lane_bad;
  logic             chk_reg;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [127:0]        data;
  logic                ready_reg;
  logic                valid_reg;
  logic [LANES*8-1:0]  orig_bytes;
  logic [LANES*8-1:0]  inv_bytes;

  // Each lane looks at byte cnt*LANES+gi of the state register.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign orig_bytes[gi*8 +: 8] = data[(int'(cnt) * LANES + gi) * 8 +: 8];
      assign inv_bytes[gi*8 +: 8]  = inv_sbox(orig_bytes[gi*8 +: 8]);
`ifdef INV_SUB_FWD_CHECK_EN
      assign lane_bad[gi] = (fwd_sbox(inv_bytes[gi*8 +: 8]) != orig_bytes[gi*8 +: 8]);
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data      <= '0;
      ready_reg <= 1'b0;
      valid_reg <= 1'b0;
`ifdef INV_SUB_FWD_CHECK_EN
      chk_reg   <= 1'b0;
`endif
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
`ifdef INV_SUB_FWD_CHECK_EN
      chk_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ready_reg <= 1'b1;
          if (in_valid && ready_reg) begin
            data      <= in_data;
            cnt       <= '0;
            state     <= BUSY;
            ready_reg <= 1'b0;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            data[(int'(cnt) * LANES + l) * 8 +: 8] <= inv_bytes[l*8 +: 8];
          end
`ifdef INV_SUB_FWD_CHECK_EN
          if (|lane_bad) chk_reg <= 1'b1;
`endif
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            valid_reg <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = valid_reg;
  assign out_data  = data;
`ifdef INV_SUB_FWD_CHECK_EN
  assign chk_err   = chk_reg;
`else
  assign chk_err   = 1'b0;
`endif

endmodule
